// File: rtl/pdm_mic_decimator.sv
// PDM microphone front-end: generates the mic clock, captures one PDM bit per mic clock period,
// and decimates each fixed window of bits into a signed 8-bit sample with optional DC removal.
module pdm_mic_decimator #(
  parameter int PDM_COUNT_PERIOD = 32,
  parameter int NUM_PDM_SAMPLES  = 256,
  parameter int DC_SHIFT         = 6
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       enable_in,
  input  logic       mic_data_in,
  output logic       mic_clk_out,
  output logic       pdm_bit_valid_out,
  output logic       pdm_bit_out,
  output logic [7:0] audio_out,
  output logic       audio_valid_out,
  output logic       clip_out
);

  localparam int CW    = $clog2(PDM_COUNT_PERIOD);
  localparam int LOG2N = $clog2(NUM_PDM_SAMPLES);
  localparam int TW    = LOG2N + 1;
  localparam int SHL   = (LOG2N <= 8) ? 8 - LOG2N : 0;
  localparam int SHR   = (LOG2N > 8) ? LOG2N - 8 : 0;

  localparam logic [CW-1:0]    CNT_MAX = CW'(PDM_COUNT_PERIOD - 1);
  localparam logic [CW-1:0]    CNT_HALF = CW'(PDM_COUNT_PERIOD / 2);
  localparam logic [LOG2N-1:0] BIT_MAX = LOG2N'(NUM_PDM_SAMPLES - 1);

  function automatic logic [8:0] sat8(input logic signed [11:0] v);
    if (v > 12'sd127) return {1'b1, 8'h7f};
    else if (v < -12'sd128) return {1'b1, 8'h80};
    else return {1'b0, v[7:0]};
  endfunction

  logic [CW-1:0]    cnt;
  logic             mic_clk_d;
  logic             rise;
  logic [LOG2N-1:0] bit_cnt;
  logic [TW-1:0]    tally;
  logic [TW-1:0]    sum_r;
  logic             win_done;
  logic [7:0]       x_r;
  logic             sat1_r;
  logic             s1_valid;
  logic [7:0]       y;
  logic             sat2;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt         <= '0;
      mic_clk_out <= 1'b0;
      mic_clk_d   <= 1'b0;
    end else if (!enable_in) begin
      cnt         <= '0;
      mic_clk_out <= 1'b0;
      mic_clk_d   <= 1'b0;
    end else begin
      cnt         <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      mic_clk_out <= (cnt < CNT_HALF);
      mic_clk_d   <= mic_clk_out;
    end
  end

  assign rise = enable_in & mic_clk_out & ~mic_clk_d;

  // The Nth bit closes the window directly into sum_r so no bit is lost between windows.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pdm_bit_valid_out <= 1'b0;
      pdm_bit_out       <= 1'b0;
      bit_cnt           <= '0;
      tally             <= '0;
      sum_r             <= '0;
      win_done          <= 1'b0;
    end else begin
      pdm_bit_valid_out <= rise;
      win_done          <= 1'b0;
      if (rise) pdm_bit_out <= mic_data_in;
      if (!enable_in) begin
        bit_cnt <= '0;
        tally   <= '0;
      end else if (rise) begin
        if (bit_cnt == BIT_MAX) begin
          sum_r    <= tally + TW'(mic_data_in);
          tally    <= '0;
          bit_cnt  <= '0;
          win_done <= 1'b1;
        end else begin
          tally   <= tally + TW'(mic_data_in);
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  logic signed [11:0] centered;
  logic signed [11:0] scaled;
  logic [8:0]         s1_res;

  assign centered = $signed(12'(sum_r)) - $signed(12'(NUM_PDM_SAMPLES / 2));
  assign scaled   = (centered <<< SHL) >>> SHR;
  assign s1_res   = sat8(scaled);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid <= 1'b0;
      x_r      <= '0;
      sat1_r   <= 1'b0;
    end else begin
      s1_valid <= win_done;
      if (win_done) begin
        x_r    <= s1_res[7:0];
        sat1_r <= s1_res[8];
      end
    end
  end

  // The DC tracker is a leaky integrator; acc keeps DC_SHIFT fraction bits below the 10-bit estimate.
  generate
    if (DC_SHIFT > 0) begin : g_dc
      localparam int AW = 10 + DC_SHIFT;
      logic signed [AW-1:0] acc;
      logic signed [9:0]    dc;
      logic signed [11:0]   diff;
      logic [8:0]           s2_res;

      assign dc     = acc[AW-1:DC_SHIFT];
      assign diff   = {{4{x_r[7]}}, x_r} - {{2{dc[9]}}, dc};
      assign s2_res = sat8(diff);
      assign y      = s2_res[7:0];
      assign sat2   = s2_res[8];

      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) acc <= '0;
        else if (s1_valid) acc <= acc + AW'(diff);
      end
    end else begin : g_nodc
      assign y    = x_r;
      assign sat2 = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      audio_valid_out <= 1'b0;
      audio_out       <= '0;
      clip_out        <= 1'b0;
    end else begin
      audio_valid_out <= s1_valid;
      if (s1_valid) begin
        audio_out <= y;
        clip_out  <= sat1_r | sat2;
      end
    end
  end

endmodule

// File: tb/tb_pdm_mic_decimator.sv
// Directed bench for pdm_mic_decimator: one instance without DC removal and one with DC_SHIFT=3,
// both on a short mic period and window so that every scenario fits in a few thousand samples.
module tb_pdm_mic_decimator;

  localparam int P = 4;
  localparam int N = 64;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic enable_in = 1'b0;
  logic mic_data;
  int   mode = 0;

  logic       mic_clk, pbv, pb, valid, clip;
  logic [7:0] audio;
  logic       dc_mic_clk, dc_pbv, dc_pb, dc_valid, dc_clip;
  logic [7:0] dc_audio;

  int         check_count = 0;
  int         pass_count = 0;
  int         cycle = 0;
  int         pulse_cnt = 0;
  int         last_bit_cyc = 0;
  logic [31:0] phase = '0;

  pdm_mic_decimator #(.PDM_COUNT_PERIOD(P), .NUM_PDM_SAMPLES(N), .DC_SHIFT(0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .mic_data_in(mic_data),
    .mic_clk_out(mic_clk), .pdm_bit_valid_out(pbv), .pdm_bit_out(pb),
    .audio_out(audio), .audio_valid_out(valid), .clip_out(clip)
  );

  pdm_mic_decimator #(.PDM_COUNT_PERIOD(P), .NUM_PDM_SAMPLES(N), .DC_SHIFT(3)) dut_dc (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .mic_data_in(mic_data),
    .mic_clk_out(dc_mic_clk), .pdm_bit_valid_out(dc_pbv), .pdm_bit_out(dc_pb),
    .audio_out(dc_audio), .audio_valid_out(dc_valid), .clip_out(dc_clip)
  );

  always #5 clk_in = ~clk_in;

  // Patterns are chosen so any N consecutive bits give the same count, independent of window alignment.
  assign mic_data = (mode == 1) | ((mode == 2) & phase[0]) | ((mode == 3) & (phase[1:0] != 2'd3));

  always @(posedge clk_in) begin
    #1;
    cycle++;
    if (pbv) begin
      pulse_cnt++;
      last_bit_cyc = cycle;
      phase = phase + 32'd1;
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic applyStimulus(input int m, input logic en);
    mode = m;
    enable_in = en;
  endtask

  task automatic waitValid(input int budget, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if (valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput({tag, "_valid_timeout"}, 0, 1);
  endtask

  task automatic waitPulses(input int base, input int count);
    for (int i = 0; i < 50 * P * count + 50; i++) begin
      @(negedge clk_in);
      if (pulse_cnt - base >= count) break;
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int base, prev_cyc, prev, cur, hi, pulses;
    int dc_exp [4];
    dc_exp[0] = 64; dc_exp[1] = 56; dc_exp[2] = 49; dc_exp[3] = 43;

    applyStimulus(1, 1'b1);
    repeat (3) @(negedge clk_in);
    checkOutput("reset_outputs", int'({mic_clk, pbv, pb, audio, valid, clip}), 0);
    checkOutput("reset_outputs_dc", int'({dc_mic_clk, dc_pbv, dc_pb, dc_audio, dc_valid, dc_clip}), 0);

    // All ones: full-scale positive saturates with clip
    rst_in = 1'b1;
    base = pulse_cnt;
    waitValid(N * P + 100, "ones1");
    checkOutput("ones_first_window_bits", pulse_cnt - base, N);
    checkOutput("ones_latency", cycle - last_bit_cyc, 2);
    checkOutput("ones_audio", $signed(audio), 127);
    checkOutput("ones_clip", int'(clip), 1);
    prev_cyc = cycle;
    waitValid(N * P + 100, "ones2");
    checkOutput("ones_period", cycle - prev_cyc, N * P);
    checkOutput("ones_latency2", cycle - last_bit_cyc, 2);
    checkOutput("ones_audio2", $signed(audio), 127);

    // Alternating bits: mid-scale zero, and mic clock duty check
    applyStimulus(2, 1'b1);
    waitValid(N * P + 100, "alt1");
    waitValid(N * P + 100, "alt2");
    checkOutput("alt_audio", $signed(audio), 0);
    checkOutput("alt_clip", int'(clip), 0);
    hi = 0;
    pulses = 0;
    for (int i = 0; i < 8 * P; i++) begin
      @(negedge clk_in);
      hi += int'(mic_clk);
      pulses += int'(pbv);
    end
    checkOutput("mic_clk_high_cycles", hi, 4 * P);
    checkOutput("bit_pulses_per_8_periods", pulses, 8);

    // All zeros: full-scale negative without clip
    applyStimulus(0, 1'b1);
    waitValid(N * P + 100, "zero1");
    waitValid(N * P + 100, "zero2");
    checkOutput("zeros_audio", $signed(audio), -128);
    checkOutput("zeros_clip", int'(clip), 0);

    // Reset in the middle of a window
    applyStimulus(1, 1'b1);
    waitValid(N * P + 100, "prerst");
    base = pulse_cnt;
    waitPulses(base, 25);
    rst_in = 1'b0;
    @(negedge clk_in);
    checkOutput("midrst_outputs", int'({mic_clk, pbv, pb, audio, valid, clip}), 0);
    mode = 0;
    repeat (5) @(negedge clk_in);
    rst_in = 1'b1;
    base = pulse_cnt;
    waitValid(N * P + 100, "postrst");
    checkOutput("postrst_window_bits", pulse_cnt - base, N);
    checkOutput("postrst_audio", $signed(audio), -128);
    checkOutput("postrst_clip", int'(clip), 0);

    // Disable right after the window closes: the in-flight sample still arrives
    applyStimulus(1, 1'b1);
    waitValid(N * P + 100, "preen1");
    waitValid(N * P + 100, "preen2");
    base = pulse_cnt;
    waitPulses(base, N);
    enable_in = 1'b0;
    waitValid(10, "inflight");
    checkOutput("inflight_audio", $signed(audio), 127);
    hi = 0;
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_in);
      hi += int'(mic_clk);
      pulses += int'(pbv) + int'(valid);
    end
    checkOutput("disabled_mic_clk_high", hi, 0);
    checkOutput("disabled_pulses", pulses, 0);
    checkOutput("disabled_audio_held", $signed(audio), 127);

    // Disable partway through a window: the partial tally is discarded
    applyStimulus(1, 1'b1);
    base = pulse_cnt;
    waitPulses(base, 20);
    enable_in = 1'b0;
    repeat (50) @(negedge clk_in);
    applyStimulus(0, 1'b1);
    base = pulse_cnt;
    waitValid(N * P + 100, "reen");
    checkOutput("reen_window_bits", pulse_cnt - base, N);
    checkOutput("reen_audio", $signed(audio), -128);
    checkOutput("reen_clip", int'(clip), 0);

    // DC removal: a constant +64 input decays towards zero
    rst_in = 1'b0;
    applyStimulus(3, 1'b1);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitValid(N * P + 100, "dc_first");
      checkOutput($sformatf("dc_sample%0d", k), $signed(dc_audio), dc_exp[k]);
      checkOutput($sformatf("dc_clip%0d", k), int'(dc_clip), 0);
      if (k == 0) checkOutput("nodc_three_quarter", $signed(audio), 64);
    end
    prev = dc_exp[3];
    for (int k = 4; k < 60; k++) begin
      waitValid(N * P + 100, "dc_decay");
      cur = $signed(dc_audio);
      checkOutput($sformatf("dc_monotonic%0d", k), int'(cur <= prev), 1);
      prev = cur;
    end
    checkOutput("dc_settled", int'(prev <= 1 && prev >= -1), 1);
    checkOutput("dc_settled_clip", int'(dc_clip), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/pdm_mic_decimator.md
Name: pdm_mic_decimator

Overview:
Front-end for the PDM microphone. It generates the microphone clock and samples the 1-bit PDM stream on each mic clock rising edge. It decimates exactly NUM_PDM_SAMPLES bits per window into a signed 8-bit sample, with optional DC removal. It feeds audio_valid/audio samples to the recorder, sine generators' step input, and the output select mux (≈12 kHz at 98.3 MHz with defaults).

Parameters:
PDM_COUNT_PERIOD, 32, clk cycles per mic clock period; even, >=4.
NUM_PDM_SAMPLES, 256, PDM bits per output sample; power of two, 64..1024.
DC_SHIFT, 6, DC-tracker time-constant shift; 0 disables DC removal.

Ports:
clk_in  input  1  system clock (98.3 MHz)
rst_in  input  1  reset, asynchronous, active-low
enable_in  input  1  1 = run; 0 = mic clock stopped, window discarded
mic_data_in  input  1  PDM data from microphone
mic_clk_out  output  1  microphone clock, registered
pdm_bit_valid_out  output  1  single-cycle pulse per captured PDM bit
pdm_bit_out  output  1  last captured PDM bit (held between pulses)
audio_out  output  8  signed decimated sample
audio_valid_out  output  1  single-cycle pulse, audio_out new
clip_out  output  1  saturation occurred for current audio_out

Behaviour:
- Reset (rst_in=0, async): all counters, tally, pipeline and DC accumulator cleared; every output 0.
- Mic clock:
  - Counter cnt runs 0..PDM_COUNT_PERIOD-1 and wraps.
  - mic_clk_out <= (cnt < PDM_COUNT_PERIOD/2).
  - mic_clk_d <= mic_clk_out.
- Bit capture:
  - On the clk edge where mic_clk_out=1 and mic_clk_d=0: pdm_bit_out <= mic_data_in, pdm_bit_valid_out <= 1.
  - Otherwise pdm_bit_valid_out <= 0.
  - Exactly one pulse per mic clock period.
- Window:
  - bit_cnt counts captured bits 0..N-1, where N=NUM_PDM_SAMPLES.
  - tally is log2(N)+1 bits wide.
  - Bit with bit_cnt<N-1: tally += bit.
  - Bit with bit_cnt=N-1 (Nth bit): sum = tally+bit is latched to stage 1; tally <= 0; bit_cnt <= 0.
  - Exactly N bits per sample, no overlap or gap.
- Stage 1 (clk after window close):
  - centered = sum - N/2, signed, range -N/2..+N/2.
  - x = centered scaled by 256/N (arithmetic shift), saturated to [-128,127].
  - sat1 = saturation flag.
- Stage 2 (next clk):
  - If DC_SHIFT>0:
    - dc = acc >>> DC_SHIFT.
    - audio_out <= sat8(x - dc).
    - acc <= acc + x - dc.
    - acc is signed, width 10+DC_SHIFT.
  - If DC_SHIFT=0: audio_out <= x.
  - audio_valid_out <= 1 for one cycle.
  - clip_out <= sat1 | sat2.
  - audio_out and clip_out hold until the next valid.
- Latency and rate:
  - audio_valid_out rises exactly 2 clk cycles after the pdm_bit_valid_out pulse carrying the Nth bit.
  - Valid pulses are spaced exactly PDM_COUNT_PERIOD*N clk cycles in steady state.
- enable_in=0:
  - cnt, mic_clk_out and mic_clk_d are forced to 0, so no bit pulses occur.
  - bit_cnt and tally are cleared, discarding the partial window.
  - Stage 1/2 samples already in flight still complete.
  - acc and the held outputs are retained.
  - On re-enable, the first window is a full N bits starting from the first new pulse.
- Reset mid-window: same restart rule as enable_in=0; no stale sample emitted after release.
- Saturation examples (N=256): sum=256 gives centered +128, which saturates to +127 with clip; sum=0 gives -128 without clip.

Test Plan:
1. DC_SHIFT=0, mic_data_in=1 constant -> audio_out=127, clip_out=1. audio_valid_out period exactly 8192 clk; each pulse 2 cycles after a bit pulse.
2. DC_SHIFT=0, mic_data_in alternating 1,0 per mic edge -> audio_out=0, clip_out=0. mic_clk_out is 16 high / 16 low.
3. DC_SHIFT=0, mic_data_in=0 constant -> audio_out=-128 (0x80), clip_out=0.
4. DC_SHIFT=6, 3 of every 4 bits =1 (sum 192, x=64) -> first sample 64, monotonically decaying. After 400 samples |audio_out|<=1, clip_out=0.
5. rst_in low after 100 bits of a window, release -> all outputs 0 during reset. First audio_valid_out follows exactly 256 bit pulses after release, with value matching the stimulus only from that point.
6. enable_in low 1000 cycles mid-window -> mic_clk_out=0 and no pulses. On resume the next sample needs a full 256 bits; a sample in flight when enable_in fell is still delivered.
